// File: rtl/regfile_pkg.sv
// Shared register-file definitions: sizes, the hardwired-zero address and
// the address/data types used by the decode, ALU and control blocks.
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/reg_word.sv
// One storage word of the register file: loads d when en is high at the
// rising clock edge and clears to zero asynchronously while rst_n is low.
module reg_word #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] word_d;
  logic [W-1:0] word_q;

  // Next-state select: take the write data on enable, otherwise hold.
  always_comb begin
    if (en) begin
      word_d = d;
    end else begin
      word_d = word_q;
    end
  end

  // Storage flop with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign q = word_q;

endmodule

// File: rtl/regfile_2r1w.sv
// 32 x 32 register file with two combinational read ports and one
// synchronous write port. Entry 0 has no storage and always reads zero.
// With BYPASS=1 a read of the register being written this cycle returns
// the incoming write data instead of the stored value.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 0
) (
  input  logic              clock,
  input  logic              ctrl_reset_n,
  input  logic              ctrl_writeEnable,
  input  logic [ADDR_W-1:0] ctrl_writeReg,
  input  logic [DATA_W-1:0] data_writeReg,
  input  logic [ADDR_W-1:0] ctrl_readRegA,
  input  logic [ADDR_W-1:0] ctrl_readRegB,
  output logic [DATA_W-1:0] data_readRegA,
  output logic [DATA_W-1:0] data_readRegB
);

  localparam int NUM_ENTRIES = 2 ** ADDR_W;

  // Entry 0 has no storage, so the decode and enables only cover 1..N-1;
  // a write aimed at address 0 therefore has nowhere to land.
  logic [NUM_ENTRIES-1:1] wsel_onehot_s;
  logic [NUM_ENTRIES-1:1] we_s;
  logic [DATA_W-1:0]      regs_s [NUM_ENTRIES];
  logic                   wr_live_s;
  logic                   byp_a_s;
  logic                   byp_b_s;
  logic [DATA_W-1:0]      rd_a_s;
  logic [DATA_W-1:0]      rd_b_s;

  // One-hot write-address decode for the storage entries.
  always_comb begin
    wsel_onehot_s = '0;
    for (int i = 1; i < NUM_ENTRIES; i++) begin
      wsel_onehot_s[i] = (ctrl_writeReg == ADDR_W'(i));
    end
  end

  // Per-register write enable: strobe qualified by the decoded select.
  always_comb begin
    we_s = wsel_onehot_s & {(NUM_ENTRIES-1){ctrl_writeEnable}};
  end

  assign regs_s[0] = '0;

  for (genvar g = 1; g < NUM_ENTRIES; g++) begin : g_word
    reg_word #(
      .W (DATA_W)
    ) u_word (
      .clk   (clock),
      .rst_n (ctrl_reset_n),
      .en    (we_s[g]),
      .d     (data_writeReg),
      .q     (regs_s[g])
    );
  end

  // A write that will actually land this cycle: out of reset, strobed, and
  // not aimed at the hardwired-zero entry.
  always_comb begin
    if (ctrl_reset_n && ctrl_writeEnable &&
        (ctrl_writeReg != ADDR_W'(ZERO_REG))) begin
      wr_live_s = 1'b1;
    end else begin
      wr_live_s = 1'b0;
    end
  end

  // Bypass hit detection per read port; never active when BYPASS is 0.
  always_comb begin
    if ((BYPASS != 0) && wr_live_s) begin
      byp_a_s = (ctrl_readRegA == ctrl_writeReg);
      byp_b_s = (ctrl_readRegB == ctrl_writeReg);
    end else begin
      byp_a_s = 1'b0;
      byp_b_s = 1'b0;
    end
  end

  // Read port A: 32:1 mux of register outputs, overridden by the bypass.
  always_comb begin
    if (byp_a_s) begin
      rd_a_s = data_writeReg;
    end else begin
      rd_a_s = regs_s[ctrl_readRegA];
    end
  end

  // Read port B: 32:1 mux of register outputs, overridden by the bypass.
  always_comb begin
    if (byp_b_s) begin
      rd_b_s = data_writeReg;
    end else begin
      rd_b_s = regs_s[ctrl_readRegB];
    end
  end

  assign data_readRegA = rd_a_s;
  assign data_readRegB = rd_b_s;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench for regfile_2r1w. Two instances share all inputs:
// dut0 without bypass, dut1 with bypass. A plain array holds the expected
// register contents and is updated at each rising edge.
module tb_regfile_2r1w;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        we    = 1'b0;
  logic [4:0]  wa    = 5'd0;
  logic [31:0] wd    = 32'd0;
  logic [4:0]  ra    = 5'd0;
  logic [4:0]  rb    = 5'd0;
  logic [31:0] a0, b0, a1, b1;
  logic [31:0] obs [4];
  logic [31:0] model [32];

  int n_tests = 0;
  int n_fail  = 0;

  always #50 clock = ~clock;

  assign obs[0] = a0;
  assign obs[1] = b0;
  assign obs[2] = a1;
  assign obs[3] = b1;

  regfile_2r1w #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut0 (
    .clock            (clock),
    .ctrl_reset_n     (rst_n),
    .ctrl_writeEnable (we),
    .ctrl_writeReg    (wa),
    .data_writeReg    (wd),
    .ctrl_readRegA    (ra),
    .ctrl_readRegB    (rb),
    .data_readRegA    (a0),
    .data_readRegB    (b0)
  );

  regfile_2r1w #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut1 (
    .clock            (clock),
    .ctrl_reset_n     (rst_n),
    .ctrl_writeEnable (we),
    .ctrl_writeReg    (wa),
    .data_writeReg    (wd),
    .ctrl_readRegA    (ra),
    .ctrl_readRegB    (rb),
    .data_readRegA    (a1),
    .data_readRegB    (b1)
  );

  // Expected read value for a port under the current inputs.
  function automatic logic [31:0] exp_rd(input logic [4:0] addr, input bit byp);
    if (!rst_n) return 32'd0;
    if (addr == 5'd0) return 32'd0;
    if (byp && we && (wa != 5'd0) && (addr == wa)) return wd;
    return model[addr];
  endfunction

  // Port index p: bit0 selects A/B, p>=2 selects the bypass instance.
  function automatic logic [31:0] exp_port(input int p);
    return exp_rd((p % 2 == 1) ? rb : ra, p >= 2);
  endfunction

  task automatic clear_model();
    for (int k = 0; k < 32; k++) model[k] = 32'd0;
  endtask

  // Advance one rising edge, applying the write to the model, then settle.
  task automatic step();
    @(posedge clock);
    if (rst_n && we && (wa != 5'd0)) model[wa] = wd;
    #1;
  endtask

  task automatic test_reset();
    clear_model();
    rst_n = 1'b0; we = 1'b1; wa = 5'd3; wd = 32'hFFFF_FFFF;
    step(); step();
    for (int a = 0; a < 32; a++) begin
      ra = 5'(a); rb = 5'(31 - a); #1;
      for (int p = 0; p < 4; p++) begin
        n_tests++;
        if (obs[p] !== 32'd0) begin
          n_fail++;
          $display("FAIL reset_state port=%0d addr=%0d got=%h exp=%h", p, a, obs[p], 32'd0);
        end
      end
    end
    // Release mid-cycle; the first write lands at the next edge.
    rst_n = 1'b1; we = 1'b1; wa = 5'd3; wd = 32'hC0FF_EE01;
    step();
    we = 1'b0; ra = 5'd3; rb = 5'd3; #1;
    n_tests++;
    if (a0 !== 32'hC0FF_EE01) begin
      n_fail++;
      $display("FAIL first_write_after_reset got=%h exp=%h", a0, 32'hC0FF_EE01);
    end
    // Fill every register with ones.
    we = 1'b1; wd = 32'hFFFF_FFFF;
    for (int i = 1; i < 32; i++) begin
      wa = 5'(i); step();
    end
    // Pending write, then reset asserted mid-cycle.
    we = 1'b1; wa = 5'd3; wd = 32'h1234_5678; #2;
    rst_n = 1'b0; clear_model();
    for (int a = 0; a < 32; a++) begin
      ra = 5'(a); rb = 5'(31 - a); #1;
      for (int p = 0; p < 4; p++) begin
        n_tests++;
        if (obs[p] !== 32'd0) begin
          n_fail++;
          $display("FAIL reset_immediate port=%0d addr=%0d got=%h exp=%h", p, a, obs[p], 32'd0);
        end
      end
    end
    step();
    rst_n = 1'b1; we = 1'b0; ra = 5'd3; rb = 5'd31; #1;
    n_tests++;
    if (a0 !== 32'd0 || b0 !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_write_ignored got=%h/%h exp=%h", a0, b0, 32'd0);
    end
  endtask

  task automatic test_basic();
    we = 1'b1; wa = 5'd5; wd = 32'h1234_5678;
    step();
    we = 1'b0; ra = 5'd5; rb = 5'd5; #1;
    n_tests++;
    if (a0 !== 32'h1234_5678 || b0 !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL basic_rd5 got=%h/%h exp=%h", a0, b0, 32'h1234_5678);
    end
    ra = 5'd4; rb = 5'd6; #1;
    n_tests++;
    if (a0 !== 32'd0 || b0 !== 32'd0) begin
      n_fail++;
      $display("FAIL basic_neighbours got=%h/%h exp=%h", a0, b0, 32'd0);
    end
  endtask

  task automatic test_zero();
    we = 1'b1; wa = 5'd0; wd = 32'hDEAD_BEEF; ra = 5'd0; rb = 5'd0; #1;
    n_tests++;
    if (a0 !== 32'd0 || a1 !== 32'd0) begin
      n_fail++;
      $display("FAIL zero_pre_edge got=%h/%h exp=%h", a0, a1, 32'd0);
    end
    step();
    we = 1'b0; #1;
    n_tests++;
    if (a0 !== 32'd0 || b1 !== 32'd0) begin
      n_fail++;
      $display("FAIL zero_post_edge got=%h/%h exp=%h", a0, b1, 32'd0);
    end
  endtask

  task automatic test_we_gating();
    we = 1'b0; wa = 5'd7; wd = 32'hA5A5_A5A5; ra = 5'd7; rb = 5'd7;
    step(); step(); step();
    n_tests++;
    if (a0 !== 32'd0 || a1 !== 32'd0) begin
      n_fail++;
      $display("FAIL we_gated got=%h/%h exp=%h", a0, a1, 32'd0);
    end
    we = 1'b1;
    step();
    we = 1'b0; #1;
    n_tests++;
    if (a0 !== 32'hA5A5_A5A5 || b1 !== 32'hA5A5_A5A5) begin
      n_fail++;
      $display("FAIL we_enabled got=%h/%h exp=%h", a0, b1, 32'hA5A5_A5A5);
    end
  endtask

  task automatic test_hazard();
    we = 1'b1; wa = 5'd9; wd = 32'h1;
    step();
    wd = 32'h2; ra = 5'd9; rb = 5'd9; #1;
    n_tests++;
    if (a0 !== 32'h1) begin
      n_fail++;
      $display("FAIL hazard_nobyp_pre got=%h exp=%h", a0, 32'h1);
    end
    n_tests++;
    if (a1 !== 32'h2) begin
      n_fail++;
      $display("FAIL hazard_byp_pre got=%h exp=%h", a1, 32'h2);
    end
    step();
    we = 1'b0; #1;
    n_tests++;
    if (a0 !== 32'h2 || a1 !== 32'h2) begin
      n_fail++;
      $display("FAIL hazard_post got=%h/%h exp=%h", a0, a1, 32'h2);
    end
  endtask

  task automatic test_sweep();
    logic [31:0] ea, eb;
    we = 1'b1;
    for (int i = 1; i < 32; i++) begin
      wa = 5'(i); wd = 32'(i) * 32'h0101_0101; step();
    end
    we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ra = 5'(i); rb = 5'(31 - i); #1;
      ea = 32'(i) * 32'h0101_0101;
      eb = 32'(31 - i) * 32'h0101_0101;
      n_tests++;
      if (a0 !== ea || a1 !== ea || b0 !== eb || b1 !== eb) begin
        n_fail++;
        $display("FAIL sweep A=%0d B=%0d got=%h/%h/%h/%h exp=%h/%h", i, 31 - i, a0, a1, b0, b1, ea, eb);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      we = ($urandom_range(0, 3) != 0);
      wa = 5'($urandom_range(0, 31));
      wd = $urandom;
      ra = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      #1;
      for (int p = 0; p < 4; p++) begin
        n_tests++;
        if (obs[p] !== exp_port(p)) begin
          n_fail++;
          $display("FAIL random_pre n=%0d port=%0d got=%h exp=%h", n, p, obs[p], exp_port(p));
        end
      end
      step();
      for (int p = 0; p < 4; p++) begin
        n_tests++;
        if (obs[p] !== exp_port(p)) begin
          n_fail++;
          $display("FAIL random_post n=%0d port=%0d got=%h exp=%h", n, p, obs[p], exp_port(p));
        end
      end
    end
    we = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_we_gating();
    test_hazard();
    test_sweep();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
